// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared definitions for the configuration-chain bitstream loader:
// FSM state encoding and counter/word sizing helpers.
package ccff_bitstream_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width needed to count 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Bits of the next word that still fit in the chain.
  function automatic int unsigned word_bits(input int unsigned word_w,
                                            input int unsigned chain_len,
                                            input int unsigned sent);
    int unsigned left;
    left = chain_len - sent;
    return (left < word_w) ? left : word_w;
  endfunction

endpackage

// File: rtl/ccff_bitstream_loader_piso.sv
// Parallel-in/serial-out word shifter with a remaining-bit count.
// bit_out is the current serial bit (a flop output), LSB first.
module ccff_piso_shifter #(
  parameter int unsigned WORD_W = 32,
  localparam int unsigned BW = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  input  logic [BW-1:0]     nbits,
  output logic              bit_out,
  output logic              last
);

  logic [WORD_W-1:0] sreg;
  logic [BW-1:0]     cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= data;
      cnt  <= nbits;
    end else if (shift && (cnt != '0)) begin
      sreg <= sreg >> 1;
      cnt  <= cnt - BW'(1);
    end
  end

  assign bit_out = sreg[0];
  assign last    = (cnt == BW'(1));

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Loads a bitstream into the configuration chain: accepts words over
// valid/ready, shifts exactly CHAIN_LEN bits out LSB-first, folds ccff_tail into a parity.
module ccff_bitstream_loader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CHAIN_LEN = 1024
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rb_parity
);

  import ccff_bitstream_loader_pkg::*;

  localparam int unsigned CNT_W = cnt_width(CHAIN_LEN);
  localparam int unsigned BW    = $clog2(WORD_W + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             par_q, par_d;
  logic             shift_en_q;
  logic             load, shift, last;
  logic [BW-1:0]    nbits;

  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    done_d  = done_q;
    err_d   = err_q;
    par_d   = par_q;
    load    = 1'b0;
    shift   = 1'b0;
    nbits   = BW'(word_bits(WORD_W, CHAIN_LEN, 32'(sent_q)));
    case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_d = FETCH;
          sent_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          par_d   = 1'b0;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
          done_d  = 1'b0;
        end else if (cfg_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
          done_d  = 1'b0;
        end else begin
          shift  = 1'b1;
          sent_d = sent_q + CNT_W'(1);
          par_d  = par_q ^ ccff_tail;
          if (last) begin
            if (sent_d == CNT_W'(CHAIN_LEN)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = FETCH;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // shift_en is registered from the next state, so it is high exactly in SHIFT cycles.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q    <= IDLE;
      sent_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      par_q      <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sent_q     <= sent_d;
      done_q     <= done_d;
      err_q      <= err_d;
      par_q      <= par_d;
      shift_en_q <= (state_d == SHIFT);
    end
  end

  ccff_piso_shifter #(.WORD_W(WORD_W)) u_piso (
    .clk     (prog_clk),
    .rst     (prog_reset),
    .load    (load),
    .shift   (shift),
    .data    (cfg_data),
    .nbits   (nbits),
    .bit_out (ccff_head),
    .last    (last)
  );

  assign cfg_ready     = (state_q == FETCH);
  assign busy          = (state_q == FETCH) || (state_q == SHIFT);
  assign ccff_shift_en = shift_en_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rb_parity     = par_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader with a 70-DFF chain model (WORD_W=32)
// and a bit-level scoreboard of the serial stream.
module tb_ccff_bitstream_loader;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CHAIN_LEN = 70;

  logic        prog_clk = 1'b0;
  logic        prog_reset;
  logic        start, abort, cfg_valid;
  logic [31:0] cfg_data;
  logic        cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic        busy, done, err, rb_parity;

  logic [69:0] chain = '0;
  logic [69:0] preload_val = '0;
  logic        preload_req = 1'b0;
  logic        exp_q[$];
  int          shift_cnt = 0;
  int          checks = 0;
  int          fails = 0;

  typedef struct {
    logic [31:0] w0, w1, w2;
    bit          stall;
    bit          start_mid;
    int          exp_shifts;
    bit          exp_done;
  } vec_t;
  vec_t vecs[4];

  always #5 prog_clk = ~prog_clk;
  assign ccff_tail = chain[69];

  ccff_bitstream_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .abort         (abort),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .rb_parity     (rb_parity)
  );

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Physical chain model plus scoreboard pop on every shifting edge.
  always @(posedge prog_clk) begin
    if (preload_req) begin
      chain <= preload_val;
    end else if (!prog_reset && ccff_shift_en === 1'b1) begin
      chain <= {chain[68:0], ccff_head};
      shift_cnt++;
      if (exp_q.size() == 0) check("unexpected_shift", 1, 0);
      else check("head_bit", ccff_head, exp_q.pop_front());
    end
  end

  function automatic logic [69:0] image(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    logic [31:0] ws[3];
    logic [69:0] img;
    ws[0] = a; ws[1] = b; ws[2] = c;
    for (int i = 0; i < 70; i++) img[69-i] = ws[i/32][i%32];
    return img;
  endfunction

  task automatic pulse_start();
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cfg_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge prog_clk);
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      cfg_data  = w;
      cfg_valid = 1'b1;
      for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
      @(negedge prog_clk);
      cfg_valid = 1'b0;
      cfg_data  = $urandom;
    end
  endtask

  task automatic run_load(input vec_t v);
    logic [69:0] prev;
    int base, sent, n;
    bit ok;
    prev = chain;
    pulse_start();
    check("start_clears_done", done, 0);
    check("start_clears_err", err, 0);
    check("busy_after_start", busy, 1);
    base = shift_cnt;
    sent = 0;
    for (int k = 0; k < 3; k++) begin
      n = (70 - sent < 32) ? 70 - sent : 32;
      if (v.stall && k == 1) begin
        wait_ready(ok);
        for (int s = 0; s < 5; s++) begin
          check("stall_ready", cfg_ready, 1);
          check("stall_shift_en", ccff_shift_en, 0);
          @(negedge prog_clk);
        end
      end
      send_word(k == 0 ? v.w0 : (k == 1 ? v.w1 : v.w2), n);
      if (v.start_mid && k == 1) begin
        @(negedge prog_clk);
        pulse_start();
      end
      sent += n;
    end
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge prog_clk);
    check("done", done, v.exp_done);
    check("shift_count", shift_cnt - base, v.exp_shifts);
    check("queue_drained", exp_q.size(), 0);
    check("chain_image", chain, image(v.w0, v.w1, v.w2));
    check("rb_parity", rb_parity, ^prev);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    vec_t v;
    int base;
    prog_reset = 1'b1;
    start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    #12;
    check("rst_ready", cfg_ready, 0);
    check("rst_shift_en", ccff_shift_en, 0);
    check("rst_outputs", {busy, done, err, rb_parity, ccff_head}, 0);
    @(negedge prog_clk); prog_reset = 1'b0;

    vecs[0] = '{32'hDEADBEEF, 32'h12345678, 32'hFFFFFFC5, 1'b0, 1'b0, 70, 1'b1};
    vecs[1] = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'h0000002A, 1'b1, 1'b0, 70, 1'b1};
    vecs[2] = '{32'h00000001, 32'h80000000, 32'h0000003F, 1'b0, 1'b1, 70, 1'b1};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFF00, 1'b1, 1'b1, 70, 1'b1};
    for (int t = 0; t < 4; t++) run_load(vecs[t]);

    // Preloaded 0x15 byte pattern: readback parity must be the XOR of those bits.
    for (int i = 0; i < 70; i++) preload_val[i] = 8'h15 >> (i % 8);
    @(negedge prog_clk); preload_req = 1'b1;
    @(negedge prog_clk); preload_req = 1'b0;
    check("preload_applied", chain, preload_val);
    run_load('{32'h13579BDF, 32'h2468ACE0, 32'h00000011, 1'b0, 1'b0, 70, 1'b1});

    // Abort after 40 shifts, then a full reload.
    pulse_start();
    base = shift_cnt;
    send_word(32'hCAFEF00D, 32);
    send_word(32'h0BADC0DE, 32);
    for (int i = 0; i < 200 && (shift_cnt - base) < 40; i++) @(negedge prog_clk);
    check("abort_point", shift_cnt - base, 40);
    abort = 1'b1;
    @(negedge prog_clk); abort = 1'b0;
    check("abort_shift_en", ccff_shift_en, 0);
    check("abort_err", err, 1);
    check("abort_done", done, 0);
    check("abort_idle", busy, 0);
    exp_q.delete();
    run_load('{32'h89ABCDEF, 32'h01234567, 32'h00000015, 1'b1, 1'b0, 70, 1'b1});

    // start+abort together mid-SHIFT: abort wins; same pair in IDLE is ignored.
    pulse_start();
    send_word(32'h55AA55AA, 32);
    repeat (3) @(negedge prog_clk);
    start = 1'b1; abort = 1'b1;
    @(negedge prog_clk); start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);
    check("start_abort_err", err, 1);
    check("start_abort_shift_en", ccff_shift_en, 0);
    exp_q.delete();
    start = 1'b1; abort = 1'b1;
    @(negedge prog_clk); start = 1'b0; abort = 1'b0;
    check("idle_start_abort_busy", busy, 0);
    check("idle_start_abort_err", err, 1);

    // Asynchronous reset in the middle of SHIFT.
    pulse_start();
    send_word(32'h7E57C0DE, 32);
    repeat (3) @(negedge prog_clk);
    check("pre_reset_shifting", ccff_shift_en, 1);
    #2 prog_reset = 1'b1;
    #1;
    check("midrst_ready", cfg_ready, 0);
    check("midrst_shift_en", ccff_shift_en, 0);
    check("midrst_outputs", {busy, done, err, rb_parity, ccff_head}, 0);
    @(negedge prog_clk); prog_reset = 1'b0;
    exp_q.delete();
    check("post_reset_idle", {busy, cfg_ready}, 0);
    run_load('{32'hFEEDFACE, 32'h31415926, 32'h00000027, 1'b0, 1'b1, 70, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
